// File: rtl/cram_axi_read_slave.sv
// AXI4 read-only responder for the code RAM: single-port synchronous memory behind a 2-entry R skid buffer.
// Define CRAM_LOADER_EN to add the load_we/load_addr/load_data bootloader write port.
module cram_axi_read_slave #(
    parameter int    ADDR_W    = 15,
    parameter int    DATA_W    = 32,
    parameter int    ID_W      = 4,
    parameter int    MEM_WORDS = 8192,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [ID_W-1:0]   s_arid,
    input  logic [31:0]       s_araddr,
    input  logic [7:0]        s_arlen,
    input  logic [2:0]        s_arsize,
    input  logic [1:0]        s_arburst,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [ID_W-1:0]   s_rid,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              s_rvalid,
    input  logic              s_rready,
`ifdef CRAM_LOADER_EN
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
`endif
    output logic              busy
);

    localparam int WA_W = ADDR_W - 2;

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [WA_W-1:0]   addr_q, addr_d;
    logic [8:0]        issueLeft_q, issueLeft_d;
    logic              fixed_q, fixed_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem [MEM_WORDS];
    logic [DATA_W-1:0] bufData_q [2];
    logic [1:0]        bufLast_q;
    logic              wrPtr_q, rdPtr_q;
    logic [1:0]        count_q;

    logic              rHs, issue, reqErr, unusedBits;

    // The memory array starts all-zero at elaboration.
    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = '0;
    end

`ifdef CRAM_LOADER_EN
    assign unusedBits = ^{s_araddr[1:0], load_addr[1:0]};

    always_ff @(posedge clk) begin
        if (load_we) mem[load_addr[ADDR_W-1:2]] <= load_data;
    end
`else
    assign unusedBits = ^s_araddr[1:0];
`endif

    assign rHs    = (count_q != 2'd0) && s_rready;
    assign reqErr = (s_arsize != 3'd2) || s_arburst[1] || (s_araddr[31:ADDR_W] != '0);

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q     <= IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            issueLeft_q <= '0;
            fixed_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            issueLeft_q <= issueLeft_d;
            fixed_q     <= fixed_d;
            err_q       <= err_d;
        end
    end

    // A read is issued only when its slot is guaranteed: buffer not full, or a beat leaves this cycle.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        issueLeft_d = issueLeft_q;
        fixed_d     = fixed_q;
        err_d       = err_q;
        s_arready   = 1'b0;
        issue       = 1'b0;
        case (state_q)
            IDLE: begin
                s_arready = !nrst;
                if (s_arvalid && s_arready) begin
                    id_d        = s_arid;
                    addr_d      = s_araddr[ADDR_W-1:2];
                    issueLeft_d = {1'b0, s_arlen} + 9'd1;
                    fixed_d     = (s_arburst == 2'd0);
                    err_d       = reqErr;
                    state_d     = BURST;
                end
            end
            BURST: begin
                issue = (issueLeft_q != 9'd0) && ((count_q != 2'd2) || rHs);
                if (issue) begin
                    issueLeft_d = issueLeft_q - 9'd1;
                    if (!fixed_q) addr_d = addr_q + 1'b1;
                end
                if (rHs && bufLast_q[rdPtr_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The memory read lands directly in the skid slot; reset discards buffered and in-flight beats.
    always_ff @(posedge clk) begin
        if (nrst) begin
            bufData_q[0] <= '0;
            bufData_q[1] <= '0;
            bufLast_q    <= '0;
            wrPtr_q      <= 1'b0;
            rdPtr_q      <= 1'b0;
            count_q      <= '0;
        end else begin
            if (issue) begin
                bufData_q[wrPtr_q] <= err_q ? '0 : mem[addr_q];
                bufLast_q[wrPtr_q] <= (issueLeft_q == 9'd1);
                wrPtr_q            <= ~wrPtr_q;
            end
            if (rHs) rdPtr_q <= ~rdPtr_q;
            count_q <= count_q + {1'b0, issue} - {1'b0, rHs};
        end
    end

    assign s_rvalid = (count_q != 2'd0);
    assign s_rdata  = bufData_q[rdPtr_q];
    assign s_rlast  = bufLast_q[rdPtr_q];
    assign s_rresp  = err_q ? 2'b10 : 2'b00;
    assign s_rid    = id_q;
    assign busy     = (state_q == BURST);

endmodule

// File: tb/tb_cram_axi_read_slave.sv
// Self-checking bench for cram_axi_read_slave: backdoor-loaded image, directed and random bursts vs. a beat-list model.
module tb_cram_axi_read_slave;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic [3:0]  s_arid = '0;
    logic [31:0] s_araddr = '0;
    logic [7:0]  s_arlen = '0;
    logic [2:0]  s_arsize = 3'd2;
    logic [1:0]  s_arburst = 2'd1;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [3:0]  s_rid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        s_rvalid;
    logic        s_rready = 1'b0;
    logic        busy;
`ifdef CRAM_LOADER_EN
    logic        load_we = 1'b0;
    logic [14:0] load_addr = '0;
    logic [31:0] load_data = '0;
`endif

    logic [31:0] model [8192];
    int          testsRun = 0;
    int          testsFailed = 0;

    cram_axi_read_slave dut (
        .clk(clk), .nrst(nrst),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
`ifdef CRAM_LOADER_EN
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic nextReady(input int mode, input int idx);
        case (mode)
            0:       return 1'b1;
            1:       return (idx % 6 == 0) || (idx % 6 == 3) || (idx % 6 == 5);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Expected beats come from the AXI rules alone: word index, wrap modulo 8192, error conditions.
    task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                                 input logic [2:0] size, input logic [3:0] id, input int mode);
        beat_t expQ[$];
        beat_t b;
        logic  isErr;
        logic  prevStall;
        int    wa;
        int    cyc;
        isErr = (size != 3'd2) || (burst >= 2'd2) || (addr >= 32'h8000);
        wa    = int'(addr[14:2]);
        for (int i = 0; i <= int'(len); i++) begin
            b.data = isErr ? 32'h0 : model[(burst == 2'd0) ? wa : (wa + i) % 8192];
            b.resp = isErr ? 2'd2 : 2'd0;
            b.last = (i == int'(len));
            expQ.push_back(b);
        end
        @(posedge clk); #1;
        s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
        s_arvalid = 1'b1; s_rready = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!s_arready && cyc < 20);
        checkOutput("arAccept", {63'd0, s_arready}, 64'd1);
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        s_rready  = nextReady(mode, 0);
        @(negedge clk);
        checkOutput("latencyNoValid", {63'd0, s_rvalid}, 64'd0);
        checkOutput("busyAfterAr", {63'd0, busy}, 64'd1);
        checkOutput("arreadyLow", {63'd0, s_arready}, 64'd0);
        cyc = 0;
        prevStall = 1'b0;
        while (expQ.size() != 0 && cyc < 1000) begin
            @(posedge clk); #1;
            s_rready = nextReady(mode, cyc + 1);
            @(negedge clk);
            cyc++;
            if (mode == 0) checkOutput("noBubble", {63'd0, s_rvalid}, 64'd1);
            if (prevStall) checkOutput("holdValid", {63'd0, s_rvalid}, 64'd1);
            if (s_rvalid) begin
                checkOutput("rdata", {32'd0, s_rdata}, {32'd0, expQ[0].data});
                checkOutput("rresp", {62'd0, s_rresp}, {62'd0, expQ[0].resp});
                checkOutput("rlast", {63'd0, s_rlast}, {63'd0, expQ[0].last});
                checkOutput("rid", {60'd0, s_rid}, {60'd0, id});
                checkOutput("noArDuringBurst", {63'd0, s_arready}, 64'd0);
                if (s_rready) void'(expQ.pop_front());
            end
            prevStall = s_rvalid && !s_rready;
        end
        checkOutput("allBeats", 64'(expQ.size()), 64'd0);
        @(posedge clk); #1;
        s_rready = 1'b0;
        @(negedge clk);
        checkOutput("arreadyBack", {63'd0, s_arready}, 64'd1);
        checkOutput("busyDone", {63'd0, busy}, 64'd0);
        checkOutput("rvalidDone", {63'd0, s_rvalid}, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) model[i] = $urandom;
        model[0] = 32'hA000_0010;
        model[1] = 32'h1234_5678;
        #1;
        for (int i = 0; i < 8192; i++) dut.mem[i] = model[i];

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstArready", {63'd0, s_arready}, 64'd0);
        checkOutput("rstRvalid", {63'd0, s_rvalid}, 64'd0);
        checkOutput("rstRlast", {63'd0, s_rlast}, 64'd0);
        checkOutput("rstRresp", {62'd0, s_rresp}, 64'd0);
        checkOutput("rstRid", {60'd0, s_rid}, 64'd0);
        checkOutput("rstRdata", {32'd0, s_rdata}, 64'd0);
        checkOutput("rstBusy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        nrst = 1'b0;
        @(negedge clk);
        checkOutput("releaseArready", {63'd0, s_arready}, 64'd1);

        applyStimulus(32'h0000_0000, 8'd0, 2'd1, 3'd2, 4'h5, 0);
        applyStimulus(32'h0000_0004, 8'd3, 2'd1, 3'd2, 4'h2, 0);
        applyStimulus(32'h0000_0004, 8'd3, 2'd1, 3'd2, 4'h3, 1);
        applyStimulus(32'h0000_7FFC, 8'd1, 2'd1, 3'd2, 4'h7, 0);
        applyStimulus(32'h0000_8000, 8'd0, 2'd1, 3'd2, 4'h1, 0);
        applyStimulus(32'h0000_0010, 8'd2, 2'd2, 3'd2, 4'h9, 0);
        applyStimulus(32'h0000_0020, 8'd1, 2'd3, 3'd2, 4'hA, 2);
        applyStimulus(32'h0000_0020, 8'd0, 2'd1, 3'd1, 4'hB, 0);
        applyStimulus(32'h0000_1236, 8'd3, 2'd0, 3'd2, 4'hC, 2);

        for (int n = 0; n < 10; n++) begin
            logic [31:0] ra;
            ra = (n == 9) ? 32'h1000_0000 : {17'd0, 15'($urandom)};
            applyStimulus(ra, 8'($urandom_range(0, 15)), 2'($urandom_range(0, 1)), 3'd2,
                          4'($urandom), 2);
        end

        @(posedge clk); #1;
        s_arid = 4'h6; s_araddr = 32'h100; s_arlen = 8'd7; s_arburst = 2'd1; s_arsize = 3'd2;
        s_arvalid = 1'b1; s_rready = 1'b1;
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        nrst = 1'b0;
        @(negedge clk);
        checkOutput("midRstRvalid", {63'd0, s_rvalid}, 64'd0);
        checkOutput("midRstBusy", {63'd0, busy}, 64'd0);
        checkOutput("midRstArready", {63'd0, s_arready}, 64'd1);
        applyStimulus(32'h0000_0008, 8'd2, 2'd1, 3'd2, 4'h4, 0);

`ifdef CRAM_LOADER_EN
        @(posedge clk); #1;
        load_we = 1'b1; load_addr = 15'h000C; load_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        load_we = 1'b0;
        model[3] = 32'hDEAD_BEEF;
        applyStimulus(32'h0000_000C, 8'd0, 2'd1, 3'd2, 4'h8, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
